// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and hazard/stall generation for an in-order pipeline,
// tracking in-flight destinations plus a single long-latency multdiv unit.
module fwd_hazard_unit #(
  parameter  int AW     = 5,
  parameter  int NSRC   = 3,
  parameter  int DEPTH  = 2,
  parameter  int MD_LAT = 32,
  localparam int SW     = $clog2(DEPTH + 1),
  localparam int CW     = $clog2(MD_LAT)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pipe_adv_i,
  input  logic                 id_valid_i,
  input  logic                 id_wr_i,
  input  logic                 id_load_i,
  input  logic [AW-1:0]        id_rd_i,
  input  logic [NSRC*AW-1:0]   id_src_i,
  input  logic [NSRC*AW-1:0]   ex_src_i,
  input  logic                 md_start_i,
  input  logic [AW-1:0]        md_rd_i,
  output logic [NSRC*SW-1:0]   fwd_sel_o,
  output logic                 stall_o,
  output logic                 md_busy_o,
  output logic                 md_done_o
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] wr_q, wr_d;
  logic [DEPTH-1:0] ld_q, ld_d;
  logic [AW-1:0]    rd_q [DEPTH];
  logic [AW-1:0]    rd_d [DEPTH];

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    md_rd_q, md_rd_d;
  logic             md_busy_q, md_busy_d;
  logic             md_done_q, md_done_d;

  logic             load_use;
  logic             md_haz;
  logic             md_go;

  // Forwarding: scan from the oldest entry down so the nearest producer wins.
  // A load still in execute has no data yet, so it is never a forwarding source.
  always_comb begin
    fwd_sel_o = '0;
    for (int p = 0; p < NSRC; p++) begin
      logic [AW-1:0] a;
      logic [SW-1:0] sel;
      a   = ex_src_i[p*AW +: AW];
      sel = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (vld_q[i] && wr_q[i] && (rd_q[i] == a) && (a != '0) && !((i == 0) && ld_q[i]))
          sel = SW'(i + 1);
      end
      fwd_sel_o[p*SW +: SW] = sel;
    end
  end

  always_comb begin
    load_use = 1'b0;
    md_haz   = md_start_i;
    for (int p = 0; p < NSRC; p++) begin
      logic [AW-1:0] s;
      s = id_src_i[p*AW +: AW];
      if (vld_q[0] && wr_q[0] && ld_q[0] && (rd_q[0] == s) && (s != '0))
        load_use = 1'b1;
      if ((md_rd_q != '0) && (s == md_rd_q))
        md_haz = 1'b1;
    end
    if (id_wr_i && (id_rd_i == md_rd_q) && (md_rd_q != '0))
      md_haz = 1'b1;
    stall_o = id_valid_i & (load_use | (md_busy_q & md_haz));
    md_go   = md_start_i & id_valid_i & ~stall_o & pipe_adv_i;
  end

  // Multdiv instructions leave the tracking pipe; their result is covered by md_rd_q.
  always_comb begin
    vld_d = vld_q;
    wr_d  = wr_q;
    ld_d  = ld_q;
    for (int i = 0; i < DEPTH; i++) rd_d[i] = rd_q[i];
    if (pipe_adv_i) begin
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        wr_d[i]  = wr_q[i-1];
        ld_d[i]  = ld_q[i-1];
        rd_d[i]  = rd_q[i-1];
      end
      vld_d[0] = id_valid_i & ~stall_o & ~md_start_i;
      wr_d[0]  = id_wr_i;
      ld_d[0]  = id_load_i;
      rd_d[0]  = id_rd_i;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    md_rd_d   = md_rd_q;
    md_busy_d = md_busy_q;
    md_done_d = 1'b0;
    if (md_busy_q) begin
      if (cnt_q == '0) begin
        md_busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) md_done_d = 1'b1;
      end
    end else if (md_go) begin
      cnt_d     = CW'(MD_LAT - 1);
      md_rd_d   = md_rd_i;
      md_busy_d = 1'b1;
    end
  end

  // Control state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q     <= '0;
      cnt_q     <= '0;
      md_rd_q   <= '0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      cnt_q     <= cnt_d;
      md_rd_q   <= md_rd_d;
      md_busy_q <= md_busy_d;
      md_done_q <= md_done_d;
    end
  end

  // Entry payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    wr_q <= wr_d;
    ld_q <= ld_d;
    for (int i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
  end

  assign md_busy_o = md_busy_q;
  assign md_done_o = md_done_q;

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter AW, default 5, register address width.
REQ-002 Parameter NSRC, default 3, number of source-operand ports per stage.
REQ-003 Parameter DEPTH, default 2, tracked in-flight stages past decode (1..7); SW = clog2(DEPTH+1).
REQ-004 Parameter MD_LAT, default 32, multdiv latency in cycles (>=2).
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 pipe_adv  in  1  pipeline advances this cycle.
REQ-008 id_valid, id_wr, id_load  in  1 each  decode instr valid / writes a register / is a load.
REQ-009 id_rd  in  AW  decode instr destination.
REQ-010 id_src  in  NSRC*AW  decode instr source registers (port p = bits p*AW+:AW).
REQ-011 ex_src  in  NSRC*AW  execute-stage instr source registers.
REQ-012 md_start  in  1  decode instr is a multdiv op; md_rd in AW its destination.
REQ-013 fwd_sel  out  NSRC*SW  per ex_src port: 0 = regfile, k = stage entry k-1.
REQ-014 stall  out  1  hold decode, insert bubble.
REQ-015 md_busy  out  1; md_done  out  1  multdiv in flight / completion pulse.

Function
REQ-016 The block SHALL hold a DEPTH-entry tracking pipe, each entry {valid, wr, rd, load}; entry 0 = execute stage, entry DEPTH-1 = writeback.
REQ-017 On a clock edge with pipe_adv=1, entry i SHALL take entry i-1, and entry 0 SHALL take {id_valid & ~stall & ~md_start, id_wr, id_rd, id_load}, else a bubble (valid=0).
REQ-018 With pipe_adv=0 all entries SHALL hold; the multdiv counter SHALL still count.
REQ-019 An entry SHALL match address a only if valid & wr & rd==a & a!=0.
REQ-020 fwd_sel[p] SHALL be combinational: k = 1 + lowest index i matching ex_src[p] (nearest stage wins), excluding entry 0 when its load=1; 0 if no match.
REQ-021 Load-use: stall SHALL assert when id_valid and any id_src[p] matches entry 0 with load=1.
REQ-022 Multdiv: md_start & id_valid & ~stall & pipe_adv SHALL load the counter with MD_LAT-1, latch md_rd, set md_busy next cycle.
REQ-023 While md_busy, the counter SHALL decrement every cycle; on the cycle it is 0, md_done SHALL pulse high for exactly one cycle and md_busy SHALL clear on the following edge.
REQ-024 While md_busy, stall SHALL assert if id_valid and (any id_src[p]==latched md_rd!=0, or id_wr & id_rd==latched md_rd!=0, or md_start).
REQ-025 A new md_start in the md_done cycle SHALL stall (no back-to-back overlap).
REQ-026 stall SHALL be 0 whenever id_valid=0; register 0 SHALL never cause stall or forwarding.
REQ-027 All outputs except md_busy/md_done SHALL be combinational from state and inputs; md_busy and md_done SHALL be registered.

Reset
REQ-028 reset=0 SHALL immediately clear all entries to invalid, counter to 0, latched md_rd to 0, md_busy=0, md_done=0.
REQ-029 While reset=0, fwd_sel SHALL be all 0 and stall SHALL be 0.
REQ-030 Reset asserted mid-multdiv SHALL abort it with no md_done pulse; release SHALL take effect on the first rising edge after deassertion.

Verification
REQ-031 Issue add r5 then sub using r5 on ex_src[0], pipe_adv=1 every cycle -> fwd_sel[0]=1 next cycle, =2 the cycle after (DEPTH=2), then 0.
REQ-032 lw r7 issued, next decode reads r7 -> stall=1 one cycle, bubble enters entry 0, then fwd_sel=2 in execute.
REQ-033 r9 in entries 0 and 1, ex_src[1]=r9 -> fwd_sel[1]=1; id_rd=0 writes followed by reads of r0 -> fwd_sel=0, stall=0.
REQ-034 md_start md_rd=r12 with MD_LAT=4 -> md_busy=1 for 4 cycles, md_done pulses on 4th; decode reading r12 stalls until md_done cycle passes.
REQ-035 pipe_adv=0 for 3 cycles with r3 in entry 0 -> fwd_sel stays 1 throughout, entries unchanged.
REQ-036 reset pulsed low at multdiv count 2 -> md_busy=0 immediately, no md_done, all fwd_sel=0.
